// File: rtl/inv_key_schedule.sv
// Reverse-order AES-128 round-key generator: forward schedule to round 10, then one backward step per accepted key.
// Latency: key_valid 10 cycles after the start edge; with INV_KS_CACHE_EN a repeated cipher key gives 1 cycle.
// Backpressure: key_out/key_round hold while key_valid & !key_ready; a held key_ready drains one key per cycle.
module inv_key_schedule #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic [KEY_W-1:0] key_out,
  output logic [3:0]       key_round,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
`ifdef INV_KS_CACHE_EN
  localparam logic [1:0] ST_HIT  = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef INV_KS_CACHE_EN
  logic [KEY_W-1:0] cache_key_q, cache_key_d;
  logic [KEY_W-1:0] cache_r10_q, cache_r10_d;
  logic             cache_vld_q, cache_vld_d;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box byte: multiplicative inverse as x^254 (0 maps to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // 32-bit subBytes: the same word-wide S-box stage the forward key expansion uses.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return {r, 24'h000000};
  endfunction

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sb_src, sb_mix;
  logic [3:0]       rc_idx;
  logic [KEY_W-1:0] fwd_key, bwd_key;

  // One shared SubWord/rcon path: forward steps feed w3 with rcon(cnt), backward steps feed w3^w2 with rcon(r-1).
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    sb_src  = (state_q == ST_FWD) ? w3 : (w3 ^ w2);
    rc_idx  = (state_q == ST_FWD) ? cnt_q : (round_q - 4'd1);
    sb_mix  = sub_word({sb_src[23:0], sb_src[31:24]}) ^ rcon(rc_idx);
    fwd_key[127:96] = w0 ^ sb_mix;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    bwd_key = {w0 ^ sb_mix, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  // Sequencer: IDLE accepts start, FWD climbs to round 10, OUT walks back to round 0 under the handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef INV_KS_CACHE_EN
    cache_key_d = cache_key_q;
    cache_r10_d = cache_r10_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = 4'd0;
`ifdef INV_KS_CACHE_EN
          if (cache_vld_q && (key_in == cache_key_q)) begin
            key_d   = cache_r10_q;
            state_d = ST_HIT;
          end else begin
            key_d       = key_in;
            state_d     = ST_FWD;
            cache_key_d = key_in;
            cache_vld_d = 1'b0;
          end
`else
          key_d   = key_in;
          state_d = ST_FWD;
`endif
        end
      end
      ST_FWD: begin
        key_d = fwd_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR - 1)) begin
          round_d = 4'(NR);
          valid_d = 1'b1;
          state_d = ST_OUT;
`ifdef INV_KS_CACHE_EN
          cache_r10_d = fwd_key;
          cache_vld_d = 1'b1;
`endif
        end
      end
      ST_OUT: begin
        if (key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = bwd_key;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef INV_KS_CACHE_EN
      ST_HIT: begin
        round_d = 4'(NR);
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Schedule state; reset aborts any schedule in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef INV_KS_CACHE_EN
  // Round-10 cache; reset drops the valid flag so the next start recomputes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key_q <= '0;
      cache_r10_q <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_r10_q <= cache_r10_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

  assign busy      = busy_q;
  assign key_out   = key_q;
  assign key_round = round_q;
  assign key_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: directed AES-128 vectors plus random keys against a forward-expansion model.
// Latency: checks start-to-valid of 10 cycles, or 1 cycle for a repeated key when INV_KS_CACHE_EN is defined.
// Backpressure: exercises key_ready stalls, ignored restarts, mid-schedule reset and start in the done cycle.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready = 1'b0;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] ref_rk [0:10];
  logic [127:0] got_rk [0:10];

`ifdef INV_KS_CACHE_EN
  localparam int REP_LAT = 1;
`else
  localparam int REP_LAT = 10;
`endif

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K5 = 128'h000102030405060708090a0b0c0d0e0f;

  inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_out   (key_out),
    .key_round (key_round),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Full forward key expansion into 44 words; round key r is words 4r..4r+3.
  task automatic build_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_key_out"}, key_out, 128'(0));
    chk({tag, "_key_round"}, 128'(key_round), 128'(0));
    chk({tag, "_key_valid"}, 128'(key_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  // Pulse start at a negedge and measure edges after the start edge until key_valid.
  task automatic do_start(input logic [127:0] k, input int exp_lat, input bit poke);
    int n;
    build_ref(k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_start", 128'(busy), 128'(1));
    n = 0;
    while (!key_valid && n < 40) begin
      if (poke && n == 3) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("start_to_valid", 128'(n), 128'(exp_lat));
  endtask

  // Consume rounds 10..0 with key_ready high except for an optional stall.
  task automatic drain(input int stall_at, input int stall_len, input bit poke,
                       input int abort_at, input bit tail);
    key_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      chk("valid", 128'(key_valid), 128'(1));
      chk("round", 128'(key_round), 128'(r));
      chk("key", key_out, ref_rk[r]);
      chk("busy_out", 128'(busy), 128'(1));
      got_rk[r] = key_out;
      if (r == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_zero("abort");
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (r == stall_at) begin
        key_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_round", 128'(key_round), 128'(r));
          chk("stall_key", key_out, ref_rk[r]);
          chk("stall_valid", 128'(key_valid), 128'(1));
        end
        key_ready = 1'b1;
      end
      if (poke && r == 7) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", 128'(done), 128'(1));
    chk("valid_after_r0", 128'(key_valid), 128'(0));
    chk("busy_after_r0", 128'(busy), 128'(0));
    if (tail) begin
      tick();
      chk("done_clear", 128'(done), 128'(0));
    end
  endtask

  initial begin
    init_sbox();

    // Reset state, with start held high during reset.
    start  = 1'b1;
    key_in = K1;
    tick();
    tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();
    chk("start_in_reset_busy", 128'(busy), 128'(0));
    chk("start_in_reset_valid", 128'(key_valid), 128'(0));

    // T1: FIPS-197 key, consumer always ready.
    do_start(K1, 10, 1'b0);
    drain(-1, 0, 1'b0, -1, 1'b1);
    chk("t1_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("t1_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("t1_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("t1_r0", got_rk[0], K1);

    // T2: stall five cycles at round 9.
    do_start(K1, REP_LAT, 1'b0);
    drain(9, 5, 1'b0, -1, 1'b1);

    // T3: restart attempts during FWD and OUT are ignored; next start lands in the done cycle.
    do_start(K1, REP_LAT, 1'b1);
    drain(-1, 0, 1'b1, -1, 1'b0);

    // T4: reset at round 6, then a fresh full schedule.
    do_start(K1, REP_LAT, 1'b0);
    drain(-1, 0, 1'b0, 6, 1'b1);
    chk_idle_zero("after_abort");
    do_start(K1, 10, 1'b0);
    drain(-1, 0, 1'b0, -1, 1'b1);

    // T5: second known key; all rounds against the model.
    do_start(K5, 10, 1'b0);
    drain(-1, 0, 1'b0, -1, 1'b1);
    chk("t5_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("t5_r0", got_rk[0], K5);

    // A different key replaced any cached entry, so K1 takes the full path again.
    do_start(K1, 10, 1'b0);
    drain(-1, 0, 1'b0, -1, 1'b1);

    // Random keys with random stalls, each followed by a repeat of the same key.
    for (int it = 0; it < 4; it++) begin
      logic [127:0] rk;
      int sa, sl;
      rk = {$urandom, $urandom, $urandom, $urandom};
      sa = int'($urandom_range(10, 0));
      sl = int'($urandom_range(4, 1));
      do_start(rk, 10, 1'b0);
      drain(sa, sl, 1'b0, -1, (it % 2) == 0);
      do_start(rk, REP_LAT, 1'b0);
      drain(-1, 0, 1'b0, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
